// File: rtl/booth_ctrl_if.sv
// Start/acknowledge handshake between a requester and the Booth multiplier
// controller.
interface booth_ctrl_if;
  logic start;
  logic res_ack;
  logic busy;
  logic done;

  modport master (
    output start,
    output res_ack,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  res_ack,
    output busy,
    output done
  );
endinterface

// File: rtl/booth_ctrl.sv
// Control FSM for a 32x32 radix-2 Booth multiplier datapath.
// Optional BOOTH_ABORT_EN adds an abort port that cancels LOAD/ITER.
module booth_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  booth_ctrl_if.slave bus,
`ifdef BOOTH_ABORT_EN
  input  logic       abort,
`endif
  input  logic [1:0] pOut,
  input  logic       cntOut,
  output logic       pSel,
  output logic       addSel,
  output logic       addResSel,
  output logic       enP,
  output logic       enA,
  output logic       enS,
  output logic       enC,
  output logic       count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   abort_w;

`ifdef BOOTH_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    pSel      = 1'b0;
    addSel    = 1'b0;
    addResSel = 1'b0;
    enP       = 1'b0;
    enA       = 1'b0;
    enS       = 1'b0;
    enC       = 1'b0;
    count     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) state_d = LOAD;
      end
      LOAD: begin
        bus.busy = 1'b1;
        if (abort_w) begin
          state_d = IDLE;
        end else begin
          enP     = 1'b1;
          enA     = 1'b1;
          enS     = 1'b1;
          enC     = 1'b1;
          state_d = ITER;
        end
      end
      ITER: begin
        bus.busy = 1'b1;
        if (abort_w) begin
          state_d = IDLE;
        end else if (cntOut) begin
          pSel  = 1'b1;
          enP   = 1'b1;
          count = 1'b1;
          // Booth recoding of the current multiplier bit pair
          unique case (1'b1)
            (pOut == 2'b01): begin
              addSel    = 1'b1;
              addResSel = 1'b0;
            end
            (pOut == 2'b10): begin
              addSel    = 1'b0;
              addResSel = 1'b0;
            end
            default: begin
              addSel    = 1'b0;
              addResSel = 1'b1;
            end
          endcase
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        bus.done = 1'b1;
        if (bus.res_ack) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_booth_ctrl.sv
// Bench for booth_ctrl with a behavioural Booth datapath and
// arithmetic product reference.
module tb_booth_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  booth_ctrl_if bus ();

  logic [1:0] pOut, pOut_f;
  logic       cntOut, cnt_f, use_dp;
  logic       pSel, addSel, addResSel;
  logic       enP, enA, enS, enC, count;
`ifdef BOOTH_ABORT_EN
  logic       abort;
`endif

  booth_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
`ifdef BOOTH_ABORT_EN
    .abort    (abort),
`endif
    .pOut     (pOut),
    .cntOut   (cntOut),
    .pSel     (pSel),
    .addSel   (addSel),
    .addResSel(addResSel),
    .enP      (enP),
    .enA      (enA),
    .enS      (enS),
    .enC      (enC),
    .count    (count)
  );

  // Behavioural Booth datapath driven by the controller
  logic [64:0] P, A, S, sum;
  logic [5:0]  cnt;
  logic [31:0] m_in, r_in;

  always_comb begin
    sum = P;
    if (!addResSel) sum = P + (addSel ? A : S);
  end

  always_ff @(posedge clk) begin
    if (enA) A <= {m_in, 33'b0};
    if (enS) S <= {(~m_in) + 32'd1, 33'b0};
    if (enP) P <= pSel ? {sum[64], sum[64:1]} : {32'b0, r_in, 1'b0};
    if (enC) cnt <= 6'd32;
    else if (count) cnt <= cnt - 6'd1;
  end

  assign pOut   = use_dp ? P[1:0] : pOut_f;
  assign cntOut = use_dp ? (cnt != 6'd0) : cnt_f;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [9:0] outs();
    return {bus.busy, bus.done, pSel, addSel, addResSel,
            enP, enA, enS, enC, count};
  endfunction

  task automatic run_op(input logic [31:0] m, input logic [31:0] r,
                        input int restart_at, output logic [63:0] res,
                        output int done_edge, output int upd);
    m_in = m;
    r_in = r;
    use_dp = 1'b1;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    done_edge = -1;
    upd = 0;
    for (int e = 1; e <= 100; e++) begin
      @(negedge clk);
      if (e == restart_at) bus.start = 1'b1;
      if (enP && pSel) upd++;
      if (bus.busy && bus.done) chk("busy_done_excl", 1, 0);
      @(posedge clk);
      #1 bus.start = 1'b0;
      if (bus.done) begin
        done_edge = e;
        break;
      end
    end
    res = P[64:1];
  endtask

  task automatic ack();
    @(negedge clk);
    bus.res_ack = 1'b1;
    @(posedge clk);
    #1 bus.res_ack = 1'b0;
    chk("ack_idle", {62'b0, bus.busy, bus.done}, 64'd0);
  endtask

  typedef struct {
    logic [31:0] m;
    logic [31:0] r;
    logic [63:0] exp;
  } op_vec_t;

  typedef struct {
    logic [1:0] p;
    logic       add_sel;
    logic       add_res_sel;
  } dec_vec_t;

  op_vec_t     ops[5];
  dec_vec_t    decs[4];
  logic [63:0] res;
  int          de, up;

  initial begin
    ops[0] = '{32'd3, 32'd5, 64'd15};
    ops[1] = '{32'd7, -32'sd6, 64'hFFFF_FFFF_FFFF_FFD6};
    ops[2] = '{32'd0, 32'd123, 64'd0};
    ops[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1};
    ops[4] = '{32'd12345, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_CFC7};
    decs[0] = '{2'b01, 1'b1, 1'b0};
    decs[1] = '{2'b10, 1'b0, 1'b0};
    decs[2] = '{2'b00, 1'b0, 1'b1};
    decs[3] = '{2'b11, 1'b0, 1'b1};

    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.res_ack = 1'b0;
    use_dp = 1'b1;
    pOut_f = 2'b00;
    cnt_f = 1'b0;
    m_in = '0;
    r_in = '0;
`ifdef BOOTH_ABORT_EN
    abort = 1'b0;
`endif
    #12;
    chk("reset_outs", {54'b0, outs()}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("idle_outs", {54'b0, outs()}, 64'd0);

    for (int i = 0; i < 5; i++) begin
      run_op(ops[i].m, ops[i].r, 0, res, de, up);
      chk($sformatf("op%0d_res", i), res, ops[i].exp);
      chk($sformatf("op%0d_lat", i), 64'(de), 64'd34);
      chk($sformatf("op%0d_upd", i), 64'(up), 64'd32);
      ack();
    end

    // start pulsed while busy must not restart or queue
    run_op(32'd3, 32'd5, 10, res, de, up);
    chk("restart_lat", 64'(de), 64'd34);
    chk("restart_res", res, 64'd15);
    ack();
    repeat (5) @(posedge clk);
    #1 chk("no_queue", {63'b0, bus.busy}, 64'd0);

    // forced decode inside ITER
    use_dp = 1'b0;
    cnt_f = 1'b1;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    chk("load_outs", {54'b0, outs()}, {54'b0, 10'b10_000_11110});
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      #1 pOut_f = decs[i].p;
      #1 chk($sformatf("dec_%b", decs[i].p), {62'b0, addSel, addResSel},
             {62'b0, decs[i].add_sel, decs[i].add_res_sel});
      chk("iter_en", {61'b0, pSel, enP, count}, 64'd7);
    end
    cnt_f = 1'b0;
    #1 chk("iter_end", {54'b0, outs()}, {54'b0, 10'b10_000_00000});
    @(posedge clk);
    #1 chk("done_state", {54'b0, outs()}, {54'b0, 10'b01_000_00000});
    @(negedge clk);
    bus.start = 1'b1;
    bus.res_ack = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    bus.res_ack = 1'b0;
    chk("both_idle", {62'b0, bus.busy, bus.done}, 64'd0);
    @(posedge clk);
    #1 chk("both_no_load", {62'b0, bus.busy, bus.done}, 64'd0);
    use_dp = 1'b1;

    // asynchronous reset mid-operation
    m_in = 32'd9;
    r_in = 32'd9;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (20) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", {54'b0, outs()}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1 chk("rst_stay_idle", {62'b0, bus.busy, bus.done}, 64'd0);

`ifdef BOOTH_ABORT_EN
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (15) @(posedge clk);
    #1 abort = 1'b1;
    #1 chk("abort_no_en", {60'b0, enP, enA, enS, enC}, 64'd0);
    @(posedge clk);
    #1 abort = 1'b0;
    chk("abort_idle", {63'b0, bus.busy}, 64'd0);
    de = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1 if (bus.done) de = 1;
    end
    chk("abort_no_done", 64'(de), 64'd0);
    run_op(32'd3, 32'd5, 0, res, de, up);
    chk("abort_after", res, 64'd15);
    ack();
`endif

    // randomized operands vs arithmetic product
    for (int i = 0; i < 8; i++) begin
      logic [31:0] m, r;
      longint      ex;
      m = $urandom;
      r = $urandom;
      if (m == 32'h8000_0000) m = 32'h8000_0001;
      ex = longint'(signed'(m)) * longint'(signed'(r));
      run_op(m, r, int'($urandom_range(2, 30)), res, de, up);
      chk($sformatf("rnd%0d_res", i), res, ex);
      chk($sformatf("rnd%0d_lat", i), 64'(de), 64'd34);
      ack();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
